// File: rtl/ir_key_event_pkg.sv
// Shared definitions for the IR key event logic: FSM state encoding and a
// constant-evaluable ceil(log2) for sizing counters.
package ir_key_event_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PRESS  = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
    localparam logic [1:0] SWITCH = 2'd3;

    // Never returns 0 so that callers can size a vector directly from the result.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/ir_release_timer.sv
// Release down-counter: reloads on every frame or repeat, and flags the cycle in
// which it would reach zero so the release decision lands one cycle later.
module ir_release_timer
    import ir_key_event_pkg::*;
#(
    parameter int RELEASE_CYC = 6_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int TW = clog2(RELEASE_CYC + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            cnt <= '0;
        else if (load)
            cnt <= TW'(RELEASE_CYC);
        else if (tick && cnt != '0)
            cnt <= cnt - TW'(1);
    end

    // The tick that takes the count from 1 to 0 is the expiry event.
    assign expired = tick && !load && (cnt == TW'(1));

endmodule

// File: rtl/ir_key_event.sv
// Turns NEC decoder frame/repeat pulses into key down/hold/up lifecycle events
// with registered outputs.
module ir_key_event
    import ir_key_event_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int RELEASE_MS = 120,
    parameter int HOLD_DELAY = 5,
    parameter int HOLD_DIV   = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       data_en,
    input  logic       repeat_en,
    input  logic [7:0] data,
    output logic [7:0] key_code,
    output logic       key_active,
    output logic       key_down,
    output logic       key_up,
    output logic       key_hold,
    output logic [7:0] hold_cnt
);

    localparam int         RELEASE_CYC  = CLK_FREQ / 1000 * RELEASE_MS;
    localparam logic [7:0] HOLD_DELAY_C = 8'(HOLD_DELAY);
    localparam logic [7:0] HOLD_DIV_C   = 8'(HOLD_DIV);

    logic [1:0] state;
    logic [7:0] rep_cnt;
    logic [7:0] div_cnt;
    logic [7:0] pend_code;
    logic       pressed;
    logic       timer_load;
    logic       timer_tick;
    logic       expired;

    assign pressed    = (state == PRESS) || (state == HOLD);
    // Leaving SWITCH is where the new press starts its release window.
    assign timer_load = data_en || (state == SWITCH) || (pressed && repeat_en);
    assign timer_tick = pressed && !repeat_en && !data_en;

    ir_release_timer #(
        .RELEASE_CYC(RELEASE_CYC)
    ) u_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (timer_load),
        .tick    (timer_tick),
        .expired (expired)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            key_code   <= '0;
            key_active <= 1'b0;
            key_down   <= 1'b0;
            key_up     <= 1'b0;
            key_hold   <= 1'b0;
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            div_cnt    <= '0;
            pend_code  <= '0;
        end else begin
            key_down <= 1'b0;
            key_up   <= 1'b0;
            key_hold <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_en) begin
                        key_code   <= data;
                        rep_cnt    <= '0;
                        hold_cnt   <= '0;
                        div_cnt    <= '0;
                        key_down   <= 1'b1;
                        key_active <= 1'b1;
                        state      <= PRESS;
                    end
                end
                PRESS, HOLD: begin
                    if (data_en) begin
                        // Old code stays on key_code for the key_up cycle.
                        pend_code <= data;
                        key_up    <= 1'b1;
                        state     <= SWITCH;
                    end else if (expired) begin
                        key_up     <= 1'b1;
                        key_active <= 1'b0;
                        state      <= IDLE;
                    end else if (repeat_en) begin
                        if (state == PRESS) begin
                            rep_cnt <= rep_cnt + 8'd1;
                            if (rep_cnt + 8'd1 == HOLD_DELAY_C) begin
                                key_hold <= 1'b1;
                                hold_cnt <= 8'd1;
                                div_cnt  <= '0;
                                state    <= HOLD;
                            end
                        end else if (div_cnt + 8'd1 == HOLD_DIV_C) begin
                            key_hold <= 1'b1;
                            div_cnt  <= '0;
                            if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                end
                SWITCH: begin
                    key_code <= data_en ? data : pend_code;
                    key_down <= 1'b1;
                    rep_cnt  <= '0;
                    hold_cnt <= '0;
                    div_cnt  <= '0;
                    state    <= PRESS;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_key_event.sv
// Scoreboard bench for ir_key_event: expected pulses are queued when stimulus
// is driven and matched against observed pulses cycle by cycle.
module tb_ir_key_event;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       data_en;
    logic       repeat_en;
    logic [7:0] data;
    logic [7:0] key_code, hold_cnt;
    logic       key_active, key_down, key_up, key_hold;
    logic [7:0] s_key_code, s_hold_cnt;
    logic       s_key_active, s_key_down, s_key_up, s_key_hold;

    ir_key_event #(.CLK_FREQ(1000), .RELEASE_MS(10), .HOLD_DELAY(2), .HOLD_DIV(2)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_en(data_en), .repeat_en(repeat_en),
        .data(data), .key_code(key_code), .key_active(key_active), .key_down(key_down),
        .key_up(key_up), .key_hold(key_hold), .hold_cnt(hold_cnt)
    );

    // Second instance only used to observe hold_cnt saturation with HOLD_DIV=1.
    ir_key_event #(.CLK_FREQ(1000), .RELEASE_MS(10), .HOLD_DELAY(2), .HOLD_DIV(1)) dut_sat (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_en(data_en), .repeat_en(repeat_en),
        .data(data), .key_code(s_key_code), .key_active(s_key_active), .key_down(s_key_down),
        .key_up(s_key_up), .key_hold(s_key_hold), .hold_cnt(s_hold_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         kind;  // 0 down, 1 up, 2 hold
        int         cyc;
        logic [7:0] code;
        logic [7:0] hc;
        logic       act;
    } ev_t;

    ev_t exp_q[$];
    int  cyc;
    int  checks;
    int  errors;

    task automatic expect_ev(input int kind, input int at, input logic [7:0] code,
                             input logic [7:0] hc, input logic act);
        exp_q.push_back('{kind, at, code, hc, act});
    endtask

    // Steps n cycles; each cycle the outputs are sampled on the falling edge
    // and any pulse is matched against the head of the scoreboard.
    task automatic advance(input int n);
        ev_t e;
        int  kind;
        repeat (n) begin
            @(negedge sys_clk);
            if (key_down | key_up | key_hold) begin
                kind = key_down ? 0 : (key_up ? 1 : 2);
                checks++;
                if (int'(key_down) + int'(key_up) + int'(key_hold) > 1) begin
                    errors++;
                    $display("FAIL onehot cyc=%0d down=%b up=%b hold=%b", cyc, key_down, key_up, key_hold);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d kind=%0d code=%h", cyc, kind, key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (kind !== e.kind || cyc !== e.cyc || key_code !== e.code ||
                        hold_cnt !== e.hc || key_active !== e.act) begin
                        errors++;
                        $display("FAIL pulse got kind=%0d cyc=%0d code=%h hc=%0d act=%b, want kind=%0d cyc=%0d code=%h hc=%0d act=%b",
                                 kind, cyc, key_code, hold_cnt, key_active,
                                 e.kind, e.cyc, e.code, e.hc, e.act);
                    end
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_pulse got none by cyc=%0d, want kind=%0d at cyc=%0d", cyc, e.kind, e.cyc);
            end
            @(posedge sys_clk);
            #1;
            cyc++;
        end
    endtask

    task automatic send_data(input logic [7:0] code, input logic rep);
        data      = code;
        data_en   = 1'b1;
        repeat_en = rep;
        advance(1);
        data_en   = 1'b0;
        repeat_en = 1'b0;
    endtask

    task automatic send_rep();
        repeat_en = 1'b1;
        advance(1);
        repeat_en = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        advance(3);
        checks++;
        if ({key_code, key_active, key_down, key_up, key_hold, hold_cnt} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got code=%h act=%b hc=%0d, want all 0", key_code, key_active, hold_cnt);
        end
        sys_rst = 1'b0;
        advance(50);
        send_rep();
        advance(15);
        checks++;
        if ({key_code, key_active, hold_cnt} !== 17'h0 || dut.state !== 2'd0) begin
            errors++;
            $display("FAIL orphan_repeat got code=%h act=%b hc=%0d state=%0d, want 0/IDLE",
                     key_code, key_active, hold_cnt, dut.state);
        end
    endtask

    task automatic test_press();
        int n;
        n = cyc;
        expect_ev(0, n + 1, 8'h45, 8'd0, 1'b1);
        expect_ev(1, n + 11, 8'h45, 8'd0, 1'b0);
        send_data(8'h45, 1'b0);
        advance(15);
        checks++;
        if (exp_q.size() != 0 || key_code !== 8'h45 || key_active !== 1'b0) begin
            errors++;
            $display("FAIL press_release got pending=%0d code=%h act=%b, want 0/45/0",
                     exp_q.size(), key_code, key_active);
        end
        exp_q.delete();
    endtask

    task automatic test_hold();
        int n;
        n = cyc;
        expect_ev(0, n + 1, 8'h16, 8'd0, 1'b1);
        send_data(8'h16, 1'b0);
        for (int r = 1; r <= 6; r++) begin
            advance(7);
            n = cyc;
            if (r % 2 == 0) expect_ev(2, n + 1, 8'h16, 8'(r / 2), 1'b1);
            send_rep();
        end
        expect_ev(1, n + 11, 8'h16, 8'd3, 1'b0);
        advance(14);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_sequence got pending=%0d, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_switch();
        int n;
        n = cyc;
        expect_ev(0, n + 1, 8'h16, 8'd0, 1'b1);
        send_data(8'h16, 1'b0);
        advance(3);
        send_rep();
        advance(3);
        n = cyc;
        expect_ev(2, n + 1, 8'h16, 8'd1, 1'b1);
        send_rep();
        advance(2);
        n = cyc;
        expect_ev(1, n + 1, 8'h16, 8'd1, 1'b1);
        expect_ev(0, n + 2, 8'h0C, 8'd0, 1'b1);
        send_data(8'h0C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (key_active !== 1'b1) begin
                errors++;
                $display("FAIL switch_active cyc=%0d got %b, want 1", cyc, key_active);
            end
            advance(1);
        end
        // Second frame arrives while in SWITCH: newest code must win.
        n = cyc;
        expect_ev(1, n + 1, 8'h0C, 8'd0, 1'b1);
        expect_ev(0, n + 2, 8'h44, 8'd0, 1'b1);
        expect_ev(1, n + 12, 8'h44, 8'd0, 1'b0);
        send_data(8'h33, 1'b0);
        send_data(8'h44, 1'b0);
        advance(12);
        checks++;
        if (exp_q.size() != 0 || key_code !== 8'h44) begin
            errors++;
            $display("FAIL switch_sequence got pending=%0d code=%h, want 0/44", exp_q.size(), key_code);
        end
        exp_q.delete();
    endtask

    task automatic test_collide();
        int n;
        n = cyc;
        expect_ev(0, n + 1, 8'h45, 8'd0, 1'b1);
        send_data(8'h45, 1'b0);
        advance(9);
        // This is the cycle the timer would expire in.
        n = cyc;
        expect_ev(1, n + 1, 8'h45, 8'd0, 1'b1);
        expect_ev(0, n + 2, 8'h0C, 8'd0, 1'b1);
        send_data(8'h0C, 1'b0);
        advance(3);
        n = cyc;
        expect_ev(1, n + 1, 8'h0C, 8'd0, 1'b1);
        expect_ev(0, n + 2, 8'h22, 8'd0, 1'b1);
        expect_ev(1, n + 12, 8'h22, 8'd0, 1'b0);
        send_data(8'h22, 1'b1);
        advance(13);
        checks++;
        if (exp_q.size() != 0 || key_active !== 1'b0) begin
            errors++;
            $display("FAIL collide_sequence got pending=%0d act=%b, want 0/0", exp_q.size(), key_active);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_sat();
        int n;
        n = cyc;
        expect_ev(0, n + 1, 8'h16, 8'd0, 1'b1);
        send_data(8'h16, 1'b0);
        advance(2);
        send_rep();
        advance(2);
        n = cyc;
        expect_ev(2, n + 1, 8'h16, 8'd1, 1'b1);
        send_rep();
        advance(3);
        sys_rst = 1'b1;
        advance(1);
        checks++;
        if ({key_code, key_active, key_down, key_up, key_hold, hold_cnt} !== 20'h0 || dut.state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_hold got code=%h act=%b hc=%0d state=%0d, want all 0",
                     key_code, key_active, hold_cnt, dut.state);
        end
        sys_rst = 1'b0;
        advance(15);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_up got pending=%0d, want 0", exp_q.size());
        end
        exp_q.delete();

        n = cyc;
        expect_ev(0, n + 1, 8'h5A, 8'd0, 1'b1);
        send_data(8'h5A, 1'b0);
        for (int r = 1; r <= 300; r++) begin
            n = cyc;
            if (r % 2 == 0) expect_ev(2, n + 1, 8'h5A, 8'(r / 2), 1'b1);
            send_rep();
            if (r == 255) begin
                checks++;
                if (s_hold_cnt !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_below got %0d, want 254", s_hold_cnt);
                end
            end
            advance(1);
        end
        checks++;
        if (s_hold_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold_cnt got %0d, want 255", s_hold_cnt);
        end
        expect_ev(1, n + 11, 8'h5A, 8'd150, 1'b0);
        advance(12);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sat_sequence got pending=%0d, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        sys_rst   = 1'b1;
        data_en   = 1'b0;
        repeat_en = 1'b0;
        data      = 8'h00;
        @(posedge sys_clk);
        #1;
        test_reset();
        test_press();
        test_hold();
        test_switch();
        test_collide();
        test_reset_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_key_event.md
Name: ir_key_event

Overview:
Downstream consumer of the NEC IR decoder's outputs. It turns raw frame and repeat pulses into clean key-press lifecycle events: down, hold (auto-repeat), and up on release timeout. It feeds display/LED/application logic so each consumer does not re-derive press and release timing. It sits between the IR decoder and the seg_led / led control blocks.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
RELEASE_MS, 120, ms with no repeat frame before release is declared (NEC repeat period is 108 ms)
HOLD_DELAY, 5, repeat frames after key_down before the first key_hold
HOLD_DIV, 2, repeat frames between successive key_hold pulses once holding

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset; synchronous and active-high
data_en  in  1  1-cycle pulse: complete new frame decoded, data valid in the same cycle
repeat_en  in  1  1-cycle pulse: NEC repeat frame received
data  in  8  decoded command byte, sampled only when data_en=1
key_code  out  8  code of the current or last key
key_active  out  1  level: a key is considered pressed
key_down  out  1  1-cycle pulse: new press
key_up  out  1  1-cycle pulse: release
key_hold  out  1  1-cycle pulse: auto-repeat tick
hold_cnt  out  8  key_hold pulses issued in the current press, saturates at 255

Behaviour:
- All outputs are registered. Reset (sys_rst=1 at a clock edge) forces state IDLE and all outputs to 0; timers and counters clear to 0.
- Reset mid-press clears everything with no key_up.
- RELEASE_CYC = CLK_FREQ/1000*RELEASE_MS. The release timer is a down-counter of width clog2(RELEASE_CYC+1).
- States: IDLE, PRESS, HOLD, SWITCH.
- IDLE:
  - data_en at cycle N: latch data into key_code, load timer=RELEASE_CYC, rep_cnt=0, hold_cnt=0.
  - At N+1: key_down=1, key_active=1, state=PRESS.
  - repeat_en in IDLE (orphan repeat) is ignored.
- PRESS:
  - repeat_en: reload timer, rep_cnt+1.
  - When the incremented rep_cnt equals HOLD_DELAY: key_hold pulse next cycle, hold_cnt=1, div counter=0, state=HOLD.
- HOLD:
  - repeat_en: reload timer, div+1.
  - When div reaches HOLD_DIV: key_hold pulse next cycle, div=0, hold_cnt+1 saturating at 255.
- PRESS/HOLD timer:
  - Decrements by 1 each cycle with no repeat_en.
  - On reaching 0: key_up pulse next cycle, key_active=0, state=IDLE.
  - key_code holds its last value.
- PRESS/HOLD data_en (new frame, same or different code):
  - Cycle N+1: key_up pulse with the old key_code still driven; state=SWITCH.
  - Cycle N+2: key_code=new data (buffered at N), key_down pulse, counters cleared, timer reloaded, state=PRESS.
  - key_active stays 1 throughout.
- SWITCH lasts exactly 1 cycle.
  - data_en arriving during SWITCH replaces the buffered code. The key_down at N+2 carries the newest code.
  - repeat_en during SWITCH is ignored.
- Priority: data_en > timeout > repeat_en. data_en in the same cycle as timer expiry takes the SWITCH path, so one key_up, not two.
- At most one of key_down/key_up/key_hold is high in any cycle.
- Latency from input pulse to output pulse: 1 cycle (2 cycles for key_down after a switch).

Decomposition:
- Shared package/include holds the state encoding (2-bit localparams IDLE=0, PRESS=1, HOLD=2, SWITCH=3) and the clog2 function. Also usable by led_ctrl.
- One sub-module, ir_release_timer: load, tick and expired ports, parameterised by RELEASE_CYC. The FSM, counters and pulse generation stay in ir_key_event.

Test Plan:
All scenarios use CLK_FREQ=1000, RELEASE_MS=10 (RELEASE_CYC=10), HOLD_DELAY=2, HOLD_DIV=2.
1. Reset then idle 50 cycles; inject repeat_en alone -> all outputs stay 0, state IDLE.
2. data_en with data=8'h45 at cycle 5, no repeats -> key_down at 6, key_code=8'h45, key_active=1; key_up exactly 11 cycles after load (timer expiry + 1); key_code stays 8'h45.
3. data_en 8'h16, then repeat_en every 8 cycles ×6 -> key_hold after 2nd repeat (hold_cnt=1), after 4th (2), after 6th (3); key_up 11 cycles after last repeat.
4. data_en 8'h0C while holding 8'h16 -> key_up with key_code=8'h16 next cycle, key_down with 8'h0C the following cycle, hold_cnt=0, key_active never drops.
5. data_en and timer expiry in the same cycle, and data_en+repeat_en simultaneous -> single key_up then key_down; repeat ignored; no double pulses.
6. sys_rst asserted mid-HOLD -> next cycle all outputs 0, no key_up; 300 repeats at HOLD_DIV=1 -> hold_cnt saturates at 255.
